// File: rtl/rst_watchdog_reset_sequencer_if.sv
// Watchdog-to-reset-tree signal bundle for rst_watchdog_reset_sequencer.
// The master side is the watchdog/firmware side that raises requests and
// reads the logged cause. The slave side is the sequencer itself.
interface rst_watchdog_reset_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             wdt_rst_req;
    logic             cause_clr;
    logic             sys_rst_n;
    logic             rst_busy;
    logic             wdt_cause;
    logic [CNT_W-1:0] wdt_count;

    modport master (
        output wdt_rst_req,
        output cause_clr,
        input  sys_rst_n,
        input  rst_busy,
        input  wdt_cause,
        input  wdt_count
    );

    modport slave (
        input  wdt_rst_req,
        input  cause_clr,
        output sys_rst_n,
        output rst_busy,
        output wdt_cause,
        output wdt_count
    );
endinterface

// File: rtl/rst_watchdog_reset_sequencer.sv
// Watchdog reset sequencer.
// Turns a rising edge on the watchdog timeout level into a stretched,
// registered active-low system reset. A blanking window follows, in which
// new requests are dropped. A sticky cause flag and a saturating event count
// are kept so boot firmware can tell a watchdog reset from a power-on reset.
// Power-on itself enters the hold state, so the reset tree always sees the
// full stretch, even when the global reset pulse is short.
module rst_watchdog_reset_sequencer #(
    parameter int HOLD_CYCLES    = 16,
    parameter int RECOVER_CYCLES = 4,
    parameter int CNT_W          = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    rst_watchdog_reset_sequencer_if.slave bus
);

    // Counter widths: enough to hold PARAM-1, never narrower than one bit.
    localparam int HOLD_W = (HOLD_CYCLES    > 1) ? $clog2(HOLD_CYCLES)    : 1;
    localparam int REC_W  = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REC_W-1:0]  REC_LAST  = REC_W'(RECOVER_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic [REC_W-1:0]  rec_cnt;
    logic [REC_W-1:0]  rec_cnt_d;
    logic              req_q;
    logic              sys_rst_n_q;
    logic              sys_rst_n_d;
    logic              rst_busy_q;
    logic              rst_busy_d;
    logic              cause_q;
    logic              cause_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              trigger;

    // Event counter increment that sticks at all-ones instead of wrapping,
    // so firmware never mistakes a storm of resets for a quiet system.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    // Rising edge of the timeout level. req_q tracks the level in every state,
    // so a level held high across the blanking window cannot re-trigger.
    assign trigger = bus.wdt_rst_req & ~req_q;

    // Next-state, counters, registered outputs and cause logging.
    always_comb begin
        state_d     = state;
        hold_cnt_d  = hold_cnt;
        rec_cnt_d   = rec_cnt;
        sys_rst_n_d = sys_rst_n_q;
        rst_busy_d  = rst_busy_q;
        cause_d     = cause_q;
        count_d     = count_q;

        // Firmware clear works in any state; an accepted trigger below wins.
        if (bus.cause_clr) begin
            cause_d = 1'b0;
            count_d = '0;
        end

        case (state)
            ST_IDLE: begin
                sys_rst_n_d = 1'b1;
                rst_busy_d  = 1'b0;
                if (trigger) begin
                    state_d     = ST_HOLD;
                    hold_cnt_d  = '0;
                    sys_rst_n_d = 1'b0;
                    rst_busy_d  = 1'b1;
                    cause_d     = 1'b1;
                    // A clear in the same cycle discards history, so this
                    // event becomes the first one logged.
                    count_d     = bus.cause_clr ? CNT_ONE : sat_inc(count_q);
                end
            end

            ST_HOLD: begin
                sys_rst_n_d = 1'b0;
                rst_busy_d  = 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    state_d     = ST_RECOVER;
                    rec_cnt_d   = '0;
                    sys_rst_n_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt + 1'b1;
                end
            end

            ST_RECOVER: begin
                sys_rst_n_d = 1'b1;
                rst_busy_d  = 1'b1;
                if (rec_cnt == REC_LAST) begin
                    state_d    = ST_IDLE;
                    rst_busy_d = 1'b0;
                end else begin
                    rec_cnt_d = rec_cnt + 1'b1;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a fresh reset stretch.
                state_d     = ST_HOLD;
                hold_cnt_d  = '0;
                sys_rst_n_d = 1'b0;
                rst_busy_d  = 1'b1;
            end
        endcase
    end

    // State and output registers; global reset starts a full hold stretch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_HOLD;
            hold_cnt    <= '0;
            rec_cnt     <= '0;
            req_q       <= 1'b0;
            sys_rst_n_q <= 1'b0;
            rst_busy_q  <= 1'b1;
            cause_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state       <= state_d;
            hold_cnt    <= hold_cnt_d;
            rec_cnt     <= rec_cnt_d;
            req_q       <= bus.wdt_rst_req;
            sys_rst_n_q <= sys_rst_n_d;
            rst_busy_q  <= rst_busy_d;
            cause_q     <= cause_d;
            count_q     <= count_d;
        end
    end

    assign bus.sys_rst_n = sys_rst_n_q;
    assign bus.rst_busy  = rst_busy_q;
    assign bus.wdt_cause = cause_q;
    assign bus.wdt_count = count_q;

endmodule

// File: tb/tb_rst_watchdog_reset_sequencer.sv
// Bench for rst_watchdog_reset_sequencer.
// A timer-style reference model (cycles left low / cycles left busy) predicts
// every registered output; predictions are queued as each cycle's stimulus is
// driven and popped when the sample is taken after the clock edge.
module tb_rst_watchdog_reset_sequencer;

    localparam int HOLD    = 16;
    localparam int REC     = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic             srn;
        logic             busy;
        logic             cause;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b1;
    int    n_checks = 0;
    int    n_fail   = 0;
    exp_t  sb_q[$];
    string cur_tag  = "init";

    int               m_low;
    int               m_busy;
    logic             m_req_q;
    logic             m_cause;
    logic [CNT_W-1:0] m_count;

    int low_seen;
    int busy_seen;

    always #5 clk = ~clk;

    rst_watchdog_reset_sequencer_if #(.CNT_W(CNT_W)) bus ();

    rst_watchdog_reset_sequencer #(
        .HOLD_CYCLES   (HOLD),
        .RECOVER_CYCLES(REC),
        .CNT_W         (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.srn   = (m_low == 0);
        e.busy  = (m_busy != 0);
        e.cause = m_cause;
        e.cnt   = m_count;
        return e;
    endfunction

    task automatic model_reset();
        m_low   = HOLD;
        m_busy  = HOLD + REC;
        m_req_q = 1'b0;
        m_cause = 1'b0;
        m_count = '0;
    endtask

    task automatic model_edge(input logic req, input logic clr);
        logic trig;
        trig = req & ~m_req_q;
        if (m_busy == 0 && trig) begin
            m_low   = HOLD;
            m_busy  = HOLD + REC;
            m_cause = 1'b1;
            if (clr)
                m_count = CNT_W'(1);
            else if (m_count != CNT_W'(CNT_MAX))
                m_count = m_count + 1'b1;
        end else begin
            if (m_low > 0)  m_low--;
            if (m_busy > 0) m_busy--;
            if (clr) begin
                m_cause = 1'b0;
                m_count = '0;
            end
        end
        m_req_q = req;
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val({cur_tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check_val({cur_tag, "_sys_rst_n"}, 32'(bus.sys_rst_n), 32'(e.srn));
        check_val({cur_tag, "_rst_busy"},  32'(bus.rst_busy),  32'(e.busy));
        check_val({cur_tag, "_wdt_cause"}, 32'(bus.wdt_cause), 32'(e.cause));
        check_val({cur_tag, "_wdt_count"}, 32'(bus.wdt_count), 32'(e.cnt));
        if (bus.sys_rst_n === 1'b0) low_seen++;
        if (bus.rst_busy === 1'b1)  busy_seen++;
    endtask

    task automatic step(input logic req, input logic clr);
        bus.wdt_rst_req = req;
        bus.cause_clr   = clr;
        model_edge(req, clr);
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic run_idle(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic apply_reset(input int cycles);
        bus.wdt_rst_req = 1'b0;
        bus.cause_clr   = 1'b0;
        rst_n = 1'b0;
        model_reset();
        sb_q.push_back(model_out());
        #1;
        compare_out();
        repeat (cycles) begin
            sb_q.push_back(model_out());
            @(posedge clk);
            #1;
            compare_out();
        end
        rst_n = 1'b1;
    endtask

    task automatic post_release_check();
        for (int i = 1; i <= HOLD + REC + 1; i++) begin
            step(1'b0, 1'b0);
            if (i == HOLD - 1)   check_val({cur_tag, "_still_low"},  32'(bus.sys_rst_n), 32'd0);
            if (i == HOLD)       check_val({cur_tag, "_released"},   32'(bus.sys_rst_n), 32'd1);
            if (i == HOLD + REC - 1) check_val({cur_tag, "_still_busy"}, 32'(bus.rst_busy), 32'd1);
            if (i == HOLD + REC) check_val({cur_tag, "_idle"},       32'(bus.rst_busy),  32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: observed no finish expected finish by 100000");
        $fatal(1);
    end

    initial begin
        bus.wdt_rst_req = 1'b0;
        bus.cause_clr   = 1'b0;
        #2;

        // Power-on reset for 3 cycles, then the full stretch.
        cur_tag = "por";
        apply_reset(3);
        post_release_check();
        check_val("por_cause", 32'(bus.wdt_cause), 32'd0);
        check_val("por_count", 32'(bus.wdt_count), 32'd0);

        // Single-cycle request from IDLE.
        cur_tag = "pulse";
        low_seen  = 0;
        busy_seen = 0;
        step(1'b1, 1'b0);
        run_idle(22);
        check_val("pulse_low_len",  32'(low_seen),  32'(HOLD));
        check_val("pulse_busy_len", 32'(busy_seen), 32'(HOLD + REC));
        check_val("pulse_cause", 32'(bus.wdt_cause), 32'd1);
        check_val("pulse_count", 32'(bus.wdt_count), 32'd1);
        step(1'b0, 1'b1);
        check_val("clr_cause", 32'(bus.wdt_cause), 32'd0);
        check_val("clr_count", 32'(bus.wdt_count), 32'd0);

        // Level held high for 40 cycles: one event only.
        cur_tag = "level";
        low_seen  = 0;
        busy_seen = 0;
        repeat (40) step(1'b1, 1'b0);
        check_val("level_low_len",  32'(low_seen),  32'(HOLD));
        check_val("level_busy_len", 32'(busy_seen), 32'(HOLD + REC));
        run_idle(2);
        check_val("level_count", 32'(bus.wdt_count), 32'd1);
        step(1'b0, 1'b1);

        // Requests during HOLD and RECOVER are ignored.
        cur_tag = "ignore";
        low_seen  = 0;
        busy_seen = 0;
        step(1'b1, 1'b0);
        run_idle(4);
        step(1'b1, 1'b0);
        run_idle(12);
        step(1'b1, 1'b0);
        run_idle(3);
        check_val("ignore_low_len",  32'(low_seen),  32'(HOLD));
        check_val("ignore_busy_len", 32'(busy_seen), 32'(HOLD + REC));
        check_val("ignore_count", 32'(bus.wdt_count), 32'd1);
        step(1'b1, 1'b0);
        check_val("ignore_count2", 32'(bus.wdt_count), 32'd2);
        step(1'b0, 1'b1);
        check_val("hold_clr_cause", 32'(bus.wdt_cause), 32'd0);
        check_val("hold_clr_count", 32'(bus.wdt_count), 32'd0);
        run_idle(20);

        // Saturation after 17 events, then clear coincident with a trigger.
        cur_tag = "sat";
        repeat (17) begin
            step(1'b1, 1'b0);
            run_idle(20);
        end
        check_val("sat_count", 32'(bus.wdt_count), 32'(CNT_MAX));
        check_val("sat_cause", 32'(bus.wdt_cause), 32'd1);
        step(1'b1, 1'b1);
        check_val("clr_vs_trig_cause", 32'(bus.wdt_cause), 32'd1);
        check_val("clr_vs_trig_count", 32'(bus.wdt_count), 32'd1);
        run_idle(20);

        // Global reset at HOLD cycle 8 of a watchdog reset.
        cur_tag = "midrst";
        step(1'b1, 1'b0);
        run_idle(8);
        check_val("midrst_pre_count", 32'(bus.wdt_count), 32'd2);
        apply_reset(2);
        check_val("midrst_cause", 32'(bus.wdt_cause), 32'd0);
        check_val("midrst_count", 32'(bus.wdt_count), 32'd0);
        check_val("midrst_srn",   32'(bus.sys_rst_n), 32'd0);
        post_release_check();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
